// File: rtl/cpu_types_pkg.sv
// Shared types for the five-stage MIPS core: data widths, register index,
// hazard-unit FSM states and the bundle of pipeline-register control strobes.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  reg_idx_t;

    localparam word_t    WORD_MAX = 32'hFFFF_FFFF;
    localparam reg_idx_t REG_ZERO = 5'd0;

    // RUN: normal flow, DWAIT: waiting on data memory, HALTED: drained and stopped
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } hazard_state_t;

    // Every control strobe the hazard unit drives, in one packed bundle
    typedef struct packed {
        logic pc_wen;
        logic ifid_wen;
        logic idex_wen;
        logic exmem_wen;
        logic memwb_wen;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic memwb_flush;
        logic halted;
    } pipe_ctrl_t;

    // Nothing moves, nothing is flushed
    localparam pipe_ctrl_t CTRL_IDLE = '{
        pc_wen: 1'b0, ifid_wen: 1'b0, idex_wen: 1'b0, exmem_wen: 1'b0, memwb_wen: 1'b0,
        ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0, memwb_flush: 1'b0,
        halted: 1'b0};

    // Whole pipeline advances, no bubbles
    localparam pipe_ctrl_t CTRL_ADVANCE = '{
        pc_wen: 1'b1, ifid_wen: 1'b1, idex_wen: 1'b1, exmem_wen: 1'b1, memwb_wen: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0, memwb_flush: 1'b0,
        halted: 1'b0};

    // Halt reached EX/MEM: freeze PC, squash everything younger, let halt retire
    localparam pipe_ctrl_t CTRL_HALT_DRAIN = '{
        pc_wen: 1'b0, ifid_wen: 1'b1, idex_wen: 1'b1, exmem_wen: 1'b1, memwb_wen: 1'b1,
        ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b1, memwb_flush: 1'b0,
        halted: 1'b0};

    // Stopped core: hold everything and report halted
    localparam pipe_ctrl_t CTRL_HALTED = '{
        pc_wen: 1'b0, ifid_wen: 1'b0, idex_wen: 1'b0, exmem_wen: 1'b0, memwb_wen: 1'b0,
        ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0, memwb_flush: 1'b0,
        halted: 1'b1};

    // Taken branch / jump: load new PC, squash the three wrong-path instructions
    localparam pipe_ctrl_t CTRL_REDIRECT = '{
        pc_wen: 1'b1, ifid_wen: 1'b1, idex_wen: 1'b1, exmem_wen: 1'b1, memwb_wen: 1'b1,
        ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b1, memwb_flush: 1'b0,
        halted: 1'b0};

    // Load-use: hold PC and IF/ID, inject one bubble into ID/EX
    localparam pipe_ctrl_t CTRL_LOAD_USE = '{
        pc_wen: 1'b0, ifid_wen: 1'b0, idex_wen: 1'b1, exmem_wen: 1'b1, memwb_wen: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b1, exmem_flush: 1'b0, memwb_flush: 1'b0,
        halted: 1'b0};

    // Fetch miss: hold PC, push a bubble into IF/ID, downstream keeps draining
    localparam pipe_ctrl_t CTRL_FETCH_MISS = '{
        pc_wen: 1'b0, ifid_wen: 1'b1, idex_wen: 1'b1, exmem_wen: 1'b1, memwb_wen: 1'b1,
        ifid_flush: 1'b1, idex_flush: 1'b0, exmem_flush: 1'b0, memwb_flush: 1'b0,
        halted: 1'b0};

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter that counts enabled cycles and sticks at all-ones.
// Cleared asynchronously by the active-low reset.
module sat_counter32
    import cpu_types_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    output word_t count
);

    word_t count_r;

    // Count enabled cycles, holding once the maximum is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 32'd0;
        end else if (en && (count_r != WORD_MAX)) begin
            count_r <= count_r + 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline control for the five-stage MIPS core. Produces the advance (wen)
// and bubble (flush) strobes for every pipeline register and the PC write
// enable, tracks data-memory waits and halt, and keeps two saturating
// performance counters (stall cycles and redirects).
module hazard_unit
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     nRST,
    input  logic     ihit,
    input  logic     dhit,
    input  reg_idx_t ifid_rs,
    input  reg_idx_t ifid_rt,
    input  logic     idex_memread,
    input  reg_idx_t idex_rt,
    input  logic     exmem_memread,
    input  logic     exmem_memwrite,
    input  logic     exmem_branch,
    input  logic     exmem_zero,
    input  logic     exmem_jump,
    input  logic     exmem_halt,
    output logic     pc_wen,
    output logic     ifid_wen,
    output logic     idex_wen,
    output logic     exmem_wen,
    output logic     memwb_wen,
    output logic     ifid_flush,
    output logic     idex_flush,
    output logic     exmem_flush,
    output logic     memwb_flush,
    output logic     halted,
    output word_t    stall_cycles,
    output word_t    flush_events
);

    hazard_state_t state_r;
    hazard_state_t next_state_s;

    logic       data_wait_s;
    logic       redirect_s;
    logic       load_use_s;
    logic       fetch_miss_s;
    logic       stall_inc_s;
    logic       flush_inc_s;
    pipe_ctrl_t ctrl_s;

    // Raw hazard conditions seen by the pipeline this cycle
    always_comb begin
        data_wait_s  = (exmem_memread | exmem_memwrite) & ~dhit;
        redirect_s   = exmem_jump | (exmem_branch & exmem_zero);
        // $0 is never a real dependency, so a load targeting it never stalls
        load_use_s   = idex_memread & (idex_rt != REG_ZERO) &
                       ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));
        fetch_miss_s = ~ihit;
    end

    // FSM state register; reset lands in RUN from any state
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next state: halt is sticky, a pending data access parks in DWAIT
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            RUN, DWAIT: begin
                if (exmem_halt) begin
                    next_state_s = HALTED;
                end else if (data_wait_s) begin
                    next_state_s = DWAIT;
                end else begin
                    next_state_s = RUN;
                end
            end
            HALTED: begin
                next_state_s = HALTED;
            end
            default: begin
                next_state_s = RUN;
            end
        endcase
    end

    // FSM outputs: prioritised strobe selection. DWAIT behaves like RUN once
    // dhit arrives, so both states share the same decision chain.
    always_comb begin
        ctrl_s      = CTRL_IDLE;
        flush_inc_s = 1'b0;
        if (!nRST) begin
            ctrl_s      = CTRL_IDLE;
            flush_inc_s = 1'b0;
        end else begin
            case (state_r)
                HALTED: begin
                    ctrl_s = CTRL_HALTED;
                end
                RUN, DWAIT: begin
                    if (exmem_halt) begin
                        ctrl_s = CTRL_HALT_DRAIN;
                    end else if (data_wait_s) begin
                        // A redirect behind a waiting access stays parked in EX/MEM
                        // and fires (and is counted) only in the dhit cycle
                        ctrl_s = CTRL_IDLE;
                    end else if (redirect_s) begin
                        ctrl_s      = CTRL_REDIRECT;
                        flush_inc_s = 1'b1;
                    end else if (load_use_s) begin
                        ctrl_s = CTRL_LOAD_USE;
                    end else if (fetch_miss_s) begin
                        ctrl_s = CTRL_FETCH_MISS;
                    end else begin
                        ctrl_s = CTRL_ADVANCE;
                    end
                end
                default: begin
                    ctrl_s = CTRL_IDLE;
                end
            endcase
        end
    end

    // Stall accounting: any live (non-halted) cycle that holds the PC
    always_comb begin
        if (nRST && (state_r != HALTED)) begin
            stall_inc_s = ~ctrl_s.pc_wen;
        end else begin
            stall_inc_s = 1'b0;
        end
    end

    sat_counter32 u_stall_ctr (
        .clk   (CLK),
        .rst_n (nRST),
        .en    (stall_inc_s),
        .count (stall_cycles)
    );

    sat_counter32 u_flush_ctr (
        .clk   (CLK),
        .rst_n (nRST),
        .en    (flush_inc_s),
        .count (flush_events)
    );

    assign pc_wen      = ctrl_s.pc_wen;
    assign ifid_wen    = ctrl_s.ifid_wen;
    assign idex_wen    = ctrl_s.idex_wen;
    assign exmem_wen   = ctrl_s.exmem_wen;
    assign memwb_wen   = ctrl_s.memwb_wen;
    assign ifid_flush  = ctrl_s.ifid_flush;
    assign idex_flush  = ctrl_s.idex_flush;
    assign exmem_flush = ctrl_s.exmem_flush;
    assign memwb_flush = ctrl_s.memwb_flush;
    assign halted      = ctrl_s.halted;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// priority rules and the two saturating counters.
module tb_hazard_unit;

    logic        CLK;
    logic        nRST;
    logic        ihit, dhit;
    logic [4:0]  ifid_rs, ifid_rt, idex_rt;
    logic        idex_memread;
    logic        exmem_memread, exmem_memwrite;
    logic        exmem_branch, exmem_zero, exmem_jump, exmem_halt;
    logic        pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic        halted;
    logic [31:0] stall_cycles, flush_events;

    int checks_r;
    int errors_r;

    // Model state
    bit     m_halted;
    longint m_stall;
    longint m_flush;

    // Strobe vector order: pc, ifid/idex/exmem/memwb wen, ifid/idex/exmem/memwb flush, halted
    logic [9:0] strobe_tbl [7] = '{
        10'b00000_0000_1,   // 0: core halted
        10'b01111_1110_0,   // 1: halt drain
        10'b00000_0000_0,   // 2: data wait
        10'b11111_1110_0,   // 3: redirect
        10'b00111_0100_0,   // 4: load-use
        10'b01111_1000_0,   // 5: fetch miss
        10'b11111_0000_0    // 6: advance
    };

    hazard_unit dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .ihit           (ihit),
        .dhit           (dhit),
        .ifid_rs        (ifid_rs),
        .ifid_rt        (ifid_rt),
        .idex_memread   (idex_memread),
        .idex_rt        (idex_rt),
        .exmem_memread  (exmem_memread),
        .exmem_memwrite (exmem_memwrite),
        .exmem_branch   (exmem_branch),
        .exmem_zero     (exmem_zero),
        .exmem_jump     (exmem_jump),
        .exmem_halt     (exmem_halt),
        .pc_wen         (pc_wen),
        .ifid_wen       (ifid_wen),
        .idex_wen       (idex_wen),
        .exmem_wen      (exmem_wen),
        .memwb_wen      (memwb_wen),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .exmem_flush    (exmem_flush),
        .memwb_flush    (memwb_flush),
        .halted         (halted),
        .stall_cycles   (stall_cycles),
        .flush_events   (flush_events)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Which rule governs this cycle, straight from the priority list
    function automatic int classify();
        if (m_halted)                                               return 0;
        if (exmem_halt)                                             return 1;
        if ((exmem_memread || exmem_memwrite) && !dhit)             return 2;
        if (exmem_jump || (exmem_branch && exmem_zero))             return 3;
        if (idex_memread && idex_rt != 5'd0 &&
            (idex_rt == ifid_rs || idex_rt == ifid_rt))             return 4;
        if (!ihit)                                                  return 5;
        return 6;
    endfunction

    function automatic longint sat_inc(input longint v);
        return (v >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v + 64'd1;
    endfunction

    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b1;
        ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rt = 5'd0;
        idex_memread = 1'b0;
        exmem_memread = 1'b0; exmem_memwrite = 1'b0;
        exmem_branch = 1'b0; exmem_zero = 1'b0; exmem_jump = 1'b0; exmem_halt = 1'b0;
    endtask

    // Called just after a falling edge with inputs set: check, clock, update model
    task automatic run_cycle(input string tag);
        int         cat;
        logic [9:0] exp_v;
        logic [9:0] obs_v;
        #1;
        cat   = classify();
        exp_v = nRST ? strobe_tbl[cat] : 10'b0;
        if (!nRST) begin
            m_halted = 1'b0; m_stall = 0; m_flush = 0;
        end
        obs_v = {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
                 ifid_flush, idex_flush, exmem_flush, memwb_flush, halted};
        check_eq({tag, "_strobes"}, {22'd0, obs_v}, {22'd0, exp_v});
        check_eq({tag, "_stalls"}, stall_cycles, m_stall[31:0]);
        check_eq({tag, "_flushes"}, flush_events, m_flush[31:0]);
        @(posedge CLK);
        if (nRST && !m_halted) begin
            if (!exp_v[9]) m_stall = sat_inc(m_stall);
            if (cat == 3)  m_flush = sat_inc(m_flush);
            if (cat == 1)  m_halted = 1'b1;
        end
        @(negedge CLK);
    endtask

    initial begin
        checks_r = 0; errors_r = 0;
        m_halted = 1'b0; m_stall = 0; m_flush = 0;
        nRST = 1'b0;
        idle_inputs();

        // Reset held: everything zero even with ihit high
        @(negedge CLK);
        run_cycle("reset");
        run_cycle("reset");
        nRST = 1'b1;
        run_cycle("release");
        run_cycle("release");

        // Load-use on rs: one bubble, then free flow
        idex_memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
        run_cycle("loaduse");
        idle_inputs();
        run_cycle("loaduse_after");
        check_eq("loaduse_stall_count", stall_cycles, 32'd1);

        // Load to $0 never stalls
        idex_memread = 1'b1; idex_rt = 5'd0; ifid_rt = 5'd0;
        run_cycle("loaduse_r0");
        idle_inputs();
        check_eq("loaduse_r0_count", stall_cycles, 32'd1);

        // Store waiting on memory with a taken branch behind it
        exmem_memwrite = 1'b1; exmem_branch = 1'b1; exmem_zero = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) run_cycle("dwait");
        check_eq("dwait_stall_count", stall_cycles, 32'd4);
        dhit = 1'b1;
        run_cycle("dwait_redirect");
        idle_inputs();
        run_cycle("post_redirect");
        check_eq("redirect_count", flush_events, 32'd1);

        // Halt drain, then sticky halted regardless of hits
        exmem_halt = 1'b1;
        run_cycle("halt_drain");
        exmem_halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ihit = 1'($urandom_range(0, 1));
            dhit = 1'($urandom_range(0, 1));
            exmem_memread = 1'($urandom_range(0, 1));
            run_cycle("halted");
        end
        idle_inputs();
        nRST = 1'b0;
        run_cycle("halt_reset");
        nRST = 1'b1;
        run_cycle("halt_exit");

        // Saturation of the stall counter
        dut.u_stall_ctr.count_r = 32'hFFFF_FFFE;
        m_stall = 64'hFFFF_FFFE;
        ihit = 1'b0;
        for (int i = 0; i < 3; i++) run_cycle("saturate");
        idle_inputs();
        run_cycle("saturate_hold");
        check_eq("saturate_value", stall_cycles, 32'hFFFF_FFFF);

        // Randomized traffic, with occasional halts and resets
        nRST = 1'b0;
        run_cycle("rand_reset");
        nRST = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            ihit           = ($urandom_range(0, 3) != 0);
            dhit           = ($urandom_range(0, 2) != 0);
            ifid_rs        = 5'($urandom_range(0, 3));
            ifid_rt        = 5'($urandom_range(0, 3));
            idex_rt        = 5'($urandom_range(0, 3));
            idex_memread   = 1'($urandom_range(0, 1));
            exmem_memread  = ($urandom_range(0, 4) == 0);
            exmem_memwrite = ($urandom_range(0, 4) == 0);
            exmem_branch   = 1'($urandom_range(0, 1));
            exmem_zero     = 1'($urandom_range(0, 1));
            exmem_jump     = ($urandom_range(0, 9) == 0);
            exmem_halt     = ($urandom_range(0, 59) == 0);
            if (m_halted && ($urandom_range(0, 5) == 0)) nRST = 1'b0;
            else if ($urandom_range(0, 199) == 0)        nRST = 1'b0;
            else                                         nRST = 1'b1;
            run_cycle("random");
        end
        nRST = 1'b1;
        idle_inputs();
        run_cycle("final");

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
